// File: rtl/mc_control_unit.sv
// ----------------------------------------------------------------------------
// mc_control_unit
//
// Multi-cycle control FSM for the RV32I core. Sequences each instruction over
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) using a shared instruction/data
// memory port with a ready handshake. The control word (ALUOp, ALUSrc,
// MemtoReg, RegData, Branch) is registered when DECODE exits and held until
// the instruction retires. Memory stalls are bounded by a wait counter;
// faults and SYSTEM opcodes park the FSM in sticky TRAP / HALT states.
//
// Optional feature macro: M_EXT_EN
//   defined   -> opcode 0110011 with inst[25]=1 decodes as M-ext (ALUOp 1001)
//                and EXEC waits for alu_done.
//   undefined -> that encoding is an illegal opcode and alu_done is unused.
//
// Parameters:
//   MEM_WAIT_MAX  max wait cycles on mem_req before a timeout trap (0 = off)
//   CNT_W         width of the retired-instruction counter
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   inst            memory read data, captured as the IR on fetch
//   mem_ready       memory completes the transfer this cycle
//   alu_done        multi-cycle ALU result valid
//   mem_req, iord   memory request, address select (0 PC, 1 ALU result)
//   ir_write        IR load strobe
//   pc_write        PC update strobe (same edge as the instret update)
//   ALUOp .. Branch datapath control word
//   trap, trap_cause, halted   sticky status
//   instret         retired-instruction count
// ----------------------------------------------------------------------------
module mc_control_unit #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             mem_ready,
    input  logic             alu_done,
    output logic             mem_req,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [3:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic [1:0]       RegData,
    output logic [1:0]       Branch,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] OP_R     = 4'b0000;
    localparam logic [3:0] OP_I     = 4'b0001;
    localparam logic [3:0] OP_BR    = 4'b0010;
    localparam logic [3:0] OP_LD    = 4'b0011;
    localparam logic [3:0] OP_ST    = 4'b0100;
    localparam logic [3:0] OP_JALR  = 4'b0101;
    localparam logic [3:0] OP_JAL   = 4'b0110;
    localparam logic [3:0] OP_AUIPC = 4'b0111;
    localparam logic [3:0] OP_LUI   = 4'b1000;
`ifdef M_EXT_EN
    localparam logic [3:0] OP_MEXT  = 4'b1001;
`endif

    localparam logic [1:0] RD_PC4 = 2'b00;
    localparam logic [1:0] RD_PCR = 2'b01;
    localparam logic [1:0] RD_ALU = 2'b10;

    localparam logic [1:0] BR_SEQ  = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JAL  = 2'b10;
    localparam logic [1:0] BR_JALR = 2'b11;

    // The wait counter only has to reach MEM_WAIT_MAX-1.
    localparam int WCW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP,
        S_HALT
    } state_t;

    state_t         state;
    logic [6:0]     ir_op;
    logic           ir_f25;
    logic [WCW-1:0] wait_cnt;

    logic [3:0] dec_op;
    logic       dec_src;
    logic       dec_m2r;
    logic [1:0] dec_rd;
    logic [1:0] dec_br;
    logic       dec_legal;
    logic       dec_sys;

    logic mem_phase;
    logic waiting;
    logic timeout_hit;

    // Only the opcode and funct7[0] of the IR steer the control word.
    logic unused_inputs;
`ifdef M_EXT_EN
    assign unused_inputs = ^{inst[31:26], inst[24:7]};
`else
    assign unused_inputs = ^{inst[31:26], inst[24:7], alu_done};
`endif

    assign mem_phase   = (state == S_FETCH) || (state == S_MEM);
    assign waiting     = mem_phase && !mem_ready;
    // Fires on the last allowed wait cycle; a ready in that cycle is a transfer, not a wait.
    assign timeout_hit = (MEM_WAIT_MAX != 0) && waiting &&
                         (32'(wait_cnt) == 32'(MEM_WAIT_MAX - 1));

    // Strobes are decoded from the registered state and forced low while rst
    // is asserted, so a reset mid-instruction never writes the register file.
    assign mem_req  = !rst && mem_phase;
    assign iord     = !rst && (state == S_MEM);
    assign ir_write = !rst && (state == S_FETCH) && mem_ready;
    assign MemRead  = !rst && (state == S_MEM) && (ALUOp == OP_LD);
    assign MemWrite = !rst && (state == S_MEM) && (ALUOp == OP_ST);
    assign RegWrite = !rst && (state == S_WB);
    assign pc_write = !rst && ((state == S_WB) ||
                               ((state == S_EXEC) && (ALUOp == OP_BR)) ||
                               ((state == S_MEM) && (ALUOp == OP_ST) && mem_ready));

    // Opcode decode of the captured IR into the next control word.
    always_comb begin
        dec_op    = OP_R;
        dec_src   = 1'b0;
        dec_m2r   = 1'b0;
        dec_rd    = RD_ALU;
        dec_br    = BR_SEQ;
        dec_legal = 1'b1;
        dec_sys   = 1'b0;
        case (ir_op)
            7'b0110011: begin
                if (ir_f25) begin
`ifdef M_EXT_EN
                    dec_op = OP_MEXT;
`else
                    dec_legal = 1'b0;
`endif
                end
            end
            7'b0010011: begin
                dec_op  = OP_I;
                dec_src = 1'b1;
            end
            7'b1100011: begin
                dec_op = OP_BR;
                dec_rd = RD_PC4;
                dec_br = BR_COND;
            end
            7'b0000011: begin
                dec_op  = OP_LD;
                dec_src = 1'b1;
                dec_m2r = 1'b1;
            end
            7'b0100011: begin
                dec_op  = OP_ST;
                dec_src = 1'b1;
                dec_rd  = RD_PC4;
            end
            7'b1100111: begin
                dec_op  = OP_JALR;
                dec_src = 1'b1;
                dec_rd  = RD_PC4;
                dec_br  = BR_JALR;
            end
            7'b1101111: begin
                dec_op = OP_JAL;
                dec_rd = RD_PC4;
                dec_br = BR_JAL;
            end
            7'b0010111: begin
                dec_op  = OP_AUIPC;
                dec_src = 1'b1;
                dec_rd  = RD_PCR;
            end
            7'b0110111: begin
                dec_op  = OP_LUI;
                dec_src = 1'b1;
            end
            7'b1110011: dec_sys = 1'b1;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Main sequencer: state, IR capture, control word, wait counter, status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            ir_op      <= '0;
            ir_f25     <= 1'b0;
            wait_cnt   <= '0;
            ALUOp      <= '0;
            ALUSrc     <= 1'b0;
            MemtoReg   <= 1'b0;
            RegData    <= '0;
            Branch     <= '0;
            trap       <= 1'b0;
            trap_cause <= '0;
            halted     <= 1'b0;
            instret    <= '0;
        end else begin
            if (mem_phase && mem_ready) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_op  <= inst[6:0];
                        ir_f25 <= inst[25];
                        state  <= S_DECODE;
                    end else if (timeout_hit) begin
                        wait_cnt   <= '0;
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                        state      <= S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (dec_sys) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!dec_legal) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                        state      <= S_TRAP;
                    end else begin
                        ALUOp    <= dec_op;
                        ALUSrc   <= dec_src;
                        MemtoReg <= dec_m2r;
                        RegData  <= dec_rd;
                        Branch   <= dec_br;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (ALUOp)
                        OP_BR: begin
                            instret <= instret + 1'b1;
                            state   <= S_FETCH;
                        end
                        OP_LD, OP_ST: state <= S_MEM;
`ifdef M_EXT_EN
                        OP_MEXT: begin
                            if (alu_done) begin
                                state <= S_WB;
                            end
                        end
`endif
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (ALUOp == OP_ST) begin
                            instret <= instret + 1'b1;
                            state   <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (timeout_hit) begin
                        wait_cnt   <= '0;
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                        state      <= S_TRAP;
                    end
                end
                S_WB: begin
                    instret <= instret + 1'b1;
                    state   <= S_FETCH;
                end
                S_TRAP:  state <= S_TRAP;
                S_HALT:  state <= S_HALT;
                default: state <= S_TRAP;
            endcase
        end
    end

endmodule
